// File: rtl/global_param_pkg.sv
// Parameters and types shared by the DDR address generators.
// The FSM state enum and the default port widths live here.
package global_param_pkg;
    localparam int DDR_ADDR_W_DEF = 32;
    localparam int BURST_W_DEF    = 8;
    localparam int LINE_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } gen_state_e;
endpackage

// File: rtl/ddr_addr_gen_2d.sv
// 2-D DDR burst address generator: line_num lines of burst_num bursts each,
// issued over a valid/ready channel. Addresses are accumulated, not multiplied.
module ddr_addr_gen_2d
    import global_param_pkg::*;
#(
    parameter int DDR_ADDR_W = DDR_ADDR_W_DEF,
    parameter int BURST_W    = BURST_W_DEF,
    parameter int LINE_W     = LINE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    input  logic [DDR_ADDR_W-1:0] st_addr,
    input  logic [BURST_W-1:0]    burst,
    input  logic [DDR_ADDR_W-1:0] step,
    input  logic [BURST_W-1:0]    burst_num,
    input  logic [DDR_ADDR_W-1:0] line_step,
    input  logic [LINE_W-1:0]     line_num,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [BURST_W-1:0]    ddr_size,
    output logic                  ddr_addr_valid,
    input  logic                  ddr_addr_ready
);
    gen_state_e            state_q, state_d;
    logic [DDR_ADDR_W-1:0] addr_q, addr_d;
    logic [DDR_ADDR_W-1:0] base_q, base_d;
    logic [DDR_ADDR_W-1:0] step_q, step_d;
    logic [DDR_ADDR_W-1:0] lstep_q, lstep_d;
    logic [BURST_W-1:0]    size_q, size_d;
    logic [BURST_W-1:0]    bnum_q, bnum_d;
    logic [BURST_W-1:0]    bcnt_q, bcnt_d;
    logic [LINE_W-1:0]     lnum_q, lnum_d;
    logic [LINE_W-1:0]     lcnt_q, lcnt_d;
    logic                  last_b, last_l;

    assign last_b = (bcnt_q == bnum_q - BURST_W'(1));
    assign last_l = (lcnt_q == lnum_q - LINE_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        step_d  = step_q;
        lstep_d = lstep_q;
        size_d  = size_q;
        bnum_d  = bnum_q;
        bcnt_d  = bcnt_q;
        lnum_d  = lnum_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = st_addr;
                    base_d  = st_addr;
                    step_d  = step;
                    lstep_d = line_step;
                    size_d  = burst;
                    bnum_d  = burst_num;
                    lnum_d  = line_num;
                    bcnt_d  = '0;
                    lcnt_d  = '0;
                    // Empty jobs skip straight to the completion pulse
                    state_d = (burst_num == '0 || line_num == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ddr_addr_ready) begin
                    if (last_b) begin
                        bcnt_d = '0;
                        if (last_l) begin
                            state_d = ST_DONE;
                        end else begin
                            lcnt_d = lcnt_q + LINE_W'(1);
                            base_d = base_q + lstep_q;
                            addr_d = base_q + lstep_q;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                        addr_d = addr_q + step_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            step_q  <= '0;
            lstep_q <= '0;
            size_q  <= '0;
            bnum_q  <= '0;
            bcnt_q  <= '0;
            lnum_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            step_q  <= step_d;
            lstep_q <= lstep_d;
            size_q  <= size_d;
            bnum_q  <= bnum_d;
            bcnt_q  <= bcnt_d;
            lnum_q  <= lnum_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign ddr_addr       = addr_q;
    assign ddr_size       = size_q;
    assign ddr_addr_valid = (state_q == ST_ISSUE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
endmodule
